// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 job sequencer.
package aes_ctrl_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int ROUND_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } job_state_t;

    function automatic logic is_busy(input job_state_t st);
        return (st == ST_LOAD) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/aes_watchdog.sv
// Saturating per-round stall counter; expired flags the cycle in which the
// count would reach TIMEOUT_CYCLES.
module aes_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at LIMIT.
    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (enable && !clear && (cnt_q >= LIMIT_M1)) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_job_ctrl.sv
// AES-128 block job sequencer: start/load/run/done handshake with a sticky
// done flag for the status PIO and a per-round stall watchdog.
module aes_job_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS     = AES128_ROUNDS,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               ack,
    input  logic               abort,
    input  logic               round_done,
    output logic               core_load,
    output logic               core_round_en,
    output logic [ROUND_W-1:0] round_idx,
    output logic               busy,
    output logic               done_flag,
    output logic               error
);

    localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS);

    job_state_t         state_q, state_d;
    logic [ROUND_W-1:0] idx_q, idx_d;
    logic               core_load_q, core_load_d;
    logic               round_en_q, round_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               wd_clear_s, wd_enable_s, wd_expired_s;

    aes_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // Next state and round index; abort outranks round_done, which outranks expiry.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wd_clear_s  = 1'b0;
        wd_enable_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                wd_clear_s = 1'b1;
                if (abort) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wd_enable_s = !round_done;
                if (abort) begin
                    state_d = ST_ERR;
                end else if (round_done) begin
                    wd_clear_s = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else if (wd_expired_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (ack && start) begin
                    state_d = ST_LOAD;
                    idx_d   = 4'd1;
                end else if (ack) begin
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ERR: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        core_load_d = (state_d == ST_LOAD);
        round_en_d  = (state_d == ST_RUN);
        busy_d      = is_busy(state_d);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            core_load_q <= 1'b0;
            round_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            core_load_q <= core_load_d;
            round_en_q  <= round_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign core_load     = core_load_q;
    assign core_round_en = round_en_q;
    assign round_idx     = idx_q;
    assign busy          = busy_q;
    assign done_flag     = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_aes_job_ctrl.sv
// Scoreboard bench for aes_job_ctrl: each driven cycle queues the expected
// output vector {core_load, core_round_en, round_idx, busy, done_flag, error}.
module tb_aes_job_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       ack = 1'b0;
    logic       abort = 1'b0;
    logic       round_done = 1'b0;
    logic       core_load, core_round_en, busy, done_flag, error;
    logic [3:0] round_idx;

    int n_checks = 0;
    int n_errors = 0;
    int load_cnt = 0;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } exp_t;
    exp_t sb_q[$];

    aes_job_ctrl #(
        .NUM_ROUNDS     (10),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (5)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .ack           (ack),
        .abort         (abort),
        .round_done    (round_done),
        .core_load     (core_load),
        .core_round_en (core_round_en),
        .round_idx     (round_idx),
        .busy          (busy),
        .done_flag     (done_flag),
        .error         (error)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] obs();
        return {core_load, core_round_en, round_idx, busy, done_flag, error};
    endfunction

    function automatic logic [8:0] e_idle();
        return 9'b0_0_0000_0_0_0;
    endfunction
    function automatic logic [8:0] e_load();
        return {1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
    endfunction
    function automatic logic [8:0] e_run(input int i);
        return {1'b0, 1'b1, 4'(i), 1'b1, 1'b0, 1'b0};
    endfunction
    function automatic logic [8:0] e_done();
        return {1'b0, 1'b0, 4'd10, 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic logic [8:0] e_err(input int i);
        return {1'b0, 1'b0, 4'(i), 1'b0, 1'b0, 1'b1};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_compare();
        exp_t e;
        logic [8:0] o;
        e = sb_q.pop_front();
        o = obs();
        check_eq(e.tag, {23'd0, o}, {23'd0, e.exp});
    endtask

    // One clock: drive inputs, queue expectation, sample #1 after the edge.
    task automatic cyc(input logic s, input logic a, input logic ab, input logic rd,
                       input logic [8:0] exp, input string tag);
        start = s; ack = a; abort = ab; round_done = rd;
        sb_q.push_back('{tag: tag, exp: exp});
        @(posedge clk);
        #1;
        start = 1'b0; ack = 1'b0; abort = 1'b0; round_done = 1'b0;
        if (core_load) load_cnt++;
        sb_compare();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back('{tag: "reset", exp: e_idle()});
        sb_compare();
        reset_n = 1'b1;

        // Stray inputs in IDLE.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, e_idle(), "stray_rd");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, e_idle(), "stray_ack");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, e_idle(), "stray_abort");

        // Nominal job, round_done every third cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, e_load(), "nom_load");
        for (int r = 1; r <= 10; r++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, e_run(r), $sformatf("nom_r%0d_a", r));
            cyc(1'b0, 1'b0, 1'b0, 1'b0, e_run(r), $sformatf("nom_r%0d_b", r));
            cyc(1'b0, 1'b0, 1'b0, 1'b1, (r < 10) ? e_run(r + 1) : e_done(),
                $sformatf("nom_rd%0d", r));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, e_done(), "nom_hold");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, e_done(), "nom_start_ign");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, e_idle(), "nom_ack");

        // Fastest job, then back-to-back start+ack.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, e_load(), "fast_load");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, e_run(1), "fast_rd_in_load");
        for (int r = 1; r <= 10; r++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, (r < 10) ? e_run(r + 1) : e_done(),
                $sformatf("fast_rd%0d", r));
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, e_load(), "b2b_load");

        // Start ignored in RUN; abort beats the last round_done.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, e_run(1), "abt_run1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, e_run(1), "abt_start_ign");
        for (int r = 1; r <= 9; r++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, e_run(r + 1), $sformatf("abt_rd%0d", r));
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, e_err(10), "abt_vs_rd10");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, e_err(10), "err_start_ign");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, e_idle(), "err_ack");

        // Watchdog: two rounds then silence, ERR 16 cycles after the 2nd pulse.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, e_load(), "to_load");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, e_run(1), "to_run1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, e_run(2), "to_rd1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, e_run(3), "to_rd2");
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, (k < 16) ? e_run(3) : e_err(3),
                $sformatf("to_wait%0d", k));
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, e_idle(), "to_ack");

        // Abort during LOAD.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, e_load(), "al_load");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, e_err(1), "al_abort");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, e_idle(), "al_ack");

        // Reset in RUN at round 5, then a clean job.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, e_load(), "rst_load");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, e_run(1), "rst_run1");
        for (int r = 1; r <= 4; r++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, e_run(r + 1), $sformatf("rst_rd%0d", r));
        end
        reset_n = 1'b0;
        #2;
        sb_q.push_back('{tag: "rst_async", exp: e_idle()});
        sb_compare();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, e_load(), "post_load");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, e_run(1), "post_run1");
        for (int r = 1; r <= 10; r++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, (r < 10) ? e_run(r + 1) : e_done(),
                $sformatf("post_rd%0d", r));
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, e_idle(), "post_ack");

        check_eq("load_count", load_cnt, 32'd7);
        check_eq("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
